// File: rtl/rx_logic_2.sv
// rx_logic_2: merges five 2-phase (toggle) request/ack receive channels into
// a single downstream fifo write port with round-robin arbitration.
//
// Ports:
//   clk            - single clock, all state on rising edge
//   reset          - synchronous active-low reset
//   fifo_push_req  - [4:0] per-channel toggle request, asynchronous to clk
//   fifo_push_data - [5*SIZE-1:0] channel k data at [SIZE*k +: SIZE]
//   fifo_push_ack  - [4:0] per-channel toggle ack, flips when item consumed
//   fifo_write     - one-cycle write strobe to downstream fifo
//   fifo_full      - downstream fifo cannot accept a write this cycle
//   fifo_data_in   - [SIZE-1:0] item written when fifo_write=1
module rx_logic_2 #(
  parameter int SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          fifo_push_req,
  input  logic [5*SIZE-1:0]   fifo_push_data,
  output logic [4:0]          fifo_push_ack,
  output logic                fifo_write,
  input  logic                fifo_full,
  output logic [SIZE-1:0]     fifo_data_in
);

  localparam int NUM_CH = 5;

  logic [NUM_CH-1:0] req_meta;
  logic [NUM_CH-1:0] req_sync;
  logic [NUM_CH-1:0] pending;
  logic [2:0]        rr;
  logic              gnt_vld;
  logic [2:0]        gnt_idx;
  logic [2:0]        rr_next;

  // A channel is pending while its synchronized request disagrees with our ack.
  assign pending = req_sync ^ fifo_push_ack;

  // First pending channel scanning rr, rr+1, ... modulo NUM_CH.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = 3'd0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_vld && pending[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = 3'(idx);
      end
    end
  end

  assign rr_next = (gnt_idx == 3'(NUM_CH - 1)) ? 3'd0 : gnt_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_meta      <= '0;
      req_sync      <= '0;
      fifo_push_ack <= '0;
      fifo_write    <= 1'b0;
      fifo_data_in  <= '0;
      rr            <= 3'd0;
    end else begin
      req_meta   <= fifo_push_req;
      req_sync   <= req_meta;
      fifo_write <= 1'b0;
      if (gnt_vld && !fifo_full) begin
        fifo_write             <= 1'b1;
        fifo_data_in           <= fifo_push_data[gnt_idx*SIZE +: SIZE];
        fifo_push_ack[gnt_idx] <= ~fifo_push_ack[gnt_idx];
        rr                     <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_rx_logic_2.sv
module tb_rx_logic_2;

  logic        clk;
  logic        reset;
  logic [4:0]  req;
  logic [39:0] data;
  logic [4:0]  ack;
  logic        wr;
  logic        full;
  logic [7:0]  dout;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [7:0] sb[$];

  rx_logic_2 #(.SIZE(8)) dut (
    .clk(clk), .reset(reset), .fifo_push_req(req), .fifo_push_data(data),
    .fifo_push_ack(ack), .fifo_write(wr), .fifo_full(full), .fifo_data_in(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected item.
  always @(negedge clk) begin
    if (reset && wr) begin
      wr_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got %0h expected no write", dout);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (dout !== e) begin
          n_fail++;
          $display("FAIL sb_data: got %0h expected %0h", dout, e);
        end
      end
    end
  end

  task automatic set_data(input int ch, input logic [7:0] v);
    data[ch*8 +: 8] = v;
  endtask

  task automatic send(input int ch, input logic [7:0] v);
    set_data(ch, v);
    req[ch] = ~req[ch];
    sb.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_write", 32'(wr), 0);
    check("rst_data", 32'(dout), 0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_ack(input int ch, input logic v);
    int n;
    n = 0;
    while (ack[ch] !== v && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ack_wait", 32'(ack[ch]), 32'(v));
  endtask

  initial begin
    int w0;
    logic [7:0] exp3 [3];
    reset = 1'b0; req = '0; data = '0; full = 1'b0;

    // Single item on channel 2 with exact latency
    do_reset();
    send(2, 8'h5A);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      check("lat_write", 32'(wr), (c == 2) ? 1 : 0);
    end
    check("single_data", 32'(dout), 32'h5A);
    check("single_ack", 32'(ack), 32'b00100);
    repeat (4) @(posedge clk);

    // Round-robin 0,1,4 from rr=0, consecutive cycles
    do_reset();
    send(0, 8'hA0); send(1, 8'hA1); send(4, 8'hA4);
    exp3[0] = 8'hA0; exp3[1] = 8'hA1; exp3[2] = 8'hA4;
    @(posedge clk); @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("rr_write", 32'(wr), 1);
      check("rr_data", 32'(dout), 32'(exp3[i]));
    end
    @(posedge clk); @(negedge clk);
    check("rr_idle", 32'(wr), 0);
    check("rr_ack", 32'(ack), 32'b10011);
    // rr must have wrapped to 0: channel 0 beats channel 4
    set_data(4, 8'hB4); req[4] = ~req[4];
    set_data(0, 8'hB0); req[0] = ~req[0];
    sb.push_back(8'hB0); sb.push_back(8'hB4);
    repeat (6) @(posedge clk);

    // Full stall on channel 3
    @(negedge clk);
    full = 1'b1;
    send(3, 8'h33);
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      check("full_nowrite", 32'(wr), 0);
    end
    check("full_ack_held", 32'(ack[3]), 0);
    full = 1'b0;
    @(posedge clk); @(negedge clk);
    check("full_release_write", 32'(wr), 1);
    check("full_release_ack", 32'(ack[3]), 1);
    repeat (3) @(posedge clk);

    // Second transaction on channel 1 returns ack to 0
    do_reset();
    w0 = wr_cnt;
    send(1, 8'h11);
    wait_ack(1, 1'b1);
    send(1, 8'h22);
    wait_ack(1, 1'b0);
    repeat (4) @(posedge clk);
    check("two_writes", 32'(wr_cnt - w0), 2);

    // Reset right after the first grant abandons the rest
    do_reset();
    send(0, 8'hC0);
    set_data(1, 8'hC1); set_data(2, 8'hC2); set_data(3, 8'hC3); set_data(4, 8'hC4);
    req = 5'b11111;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    req   = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_ack", 32'(ack), 0);
    check("midrst_write", 32'(wr), 0);
    check("midrst_data", 32'(dout), 0);
    w0 = wr_cnt;
    repeat (6) @(posedge clk);
    check("midrst_nowrites", 32'(wr_cnt - w0), 0);
    send(2, 8'h77);
    wait_ack(2, 1'b1);
    repeat (3) @(posedge clk);

    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/rx_logic_2.md
RX_LOGIC_2 -- requirements
Module: rx_logic_2

Interface
REQ-001 SHALL have parameter SIZE, default 8, giving the item width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port fifo_push_req, input, 5 bits: 2-phase request per rx transceiver; a toggle means a new item is offered; asynchronous to clk.
REQ-005 SHALL have port fifo_push_data, input, 5*SIZE bits: channel k data in bits [SIZE*k+SIZE-1 : SIZE*k]; stable from before the req toggle until the matching ack toggle.
REQ-006 SHALL have port fifo_push_ack, output, 5 bits: 2-phase ack per channel; a toggle means the item was consumed.
REQ-007 SHALL have port fifo_write, output, 1 bit: one-cycle write strobe to the downstream fifo.
REQ-008 SHALL have port fifo_full, input, 1 bit: the downstream fifo cannot accept a write this cycle.
REQ-009 SHALL have port fifo_data_in, output, SIZE bits: item written when fifo_write=1.

Function
REQ-010 SHALL pass each fifo_push_req bit through a two-flop synchronizer (req_sync) before any use.
REQ-011 SHALL define pending[k] = req_sync[k] XOR fifo_push_ack[k]; no other condition marks a channel pending.
REQ-012 SHALL keep a 3-bit round-robin pointer rr (0..4) naming the highest-priority channel.
REQ-013 On each edge with fifo_full=0 and any pending bit set, SHALL grant the first pending channel searching rr, rr+1, ... modulo 5.
REQ-014 On a grant to channel g, at that same edge SHALL: set fifo_write=1, load fifo_data_in with channel g's data, toggle fifo_push_ack[g], and set rr to (g+1) mod 5, wrapping 4 to 0.
REQ-015 On edges with no grant, SHALL set fifo_write=0 and hold fifo_data_in, fifo_push_ack and rr.
REQ-016 SHALL grant at most one channel per cycle, so there is at most one fifo write per cycle.
REQ-017 Latency: a req toggle sampled at edge N SHALL cause the grant at edge N+2 at the earliest, when the fifo is not full and no other channel has priority.
REQ-018 With fifo_full=1, SHALL make no grant; pending channels stay pending and are granted on the first edge with fifo_full=0.
REQ-019 After a grant to channel g, the bit pending[g] SHALL be 0 from the next cycle until the sender toggles req again; the same item SHALL never be written twice.
REQ-020 If all 5 channels are pending together, SHALL grant them in 5 consecutive non-full cycles in round-robin order starting at rr.
REQ-021 A sender toggling req before receiving its ack is a protocol violation; behaviour for that channel is then unspecified, but other channels SHALL be unaffected.

Reset
REQ-022 While reset=0 at an edge, SHALL clear fifo_push_ack, fifo_write, fifo_data_in, rr and both synchronizer stages to 0.
REQ-023 Reset asserted mid-transfer SHALL abandon any un-acked item; transmitters are reset together with this block, so req=0 matches ack=0 and nothing is pending.
REQ-024 On the first edge after reset releases, SHALL make no grant, because the synchronizers hold 0.

Verification
REQ-025 Single item: after reset, channel 2 data=0x5A, toggle req[2] -> fifo_write=1 with fifo_data_in=0x5A exactly two edges after the toggle is sampled; ack[2]=1; no further write.
REQ-026 Round-robin: channels 0, 1 and 4 pending simultaneously with rr=0 -> writes in order 0, 1, 4 on three consecutive cycles; final rr=0 (wrap from 4).
REQ-027 Full stall: channel 3 pending, fifo_full=1 for 10 cycles -> no write and ack[3] unchanged; fifo_full drops -> one write at the next edge.
REQ-028 Second transaction: channel 1 sends 0x11, gets ack, then toggles req back to 0 with data 0x22 -> exactly two writes (0x11, 0x22); ack[1] returns to 0.
REQ-029 Reset mid-operation: 5 channels pending, reset=0 for one edge after the first grant -> all outputs 0; no writes until fresh req toggles are synchronized.
